pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the 11-bit fetch path. Owns the PC register and drives the existing combinational `pc_adder` (PC → PC+1) as an external datapath element. Issues fetch addresses to instruction memory over a valid/ready handshake, applies branch redirects, and supports halt/resume. An optional return-address stack can be compiled in.

## Interface
Parameters:
- DATA_WIDTH, 11, PC and address width.
- RESET_ADDR, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-stack entries; power of two; used only with the macro.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_adder_in  out  DATA_WIDTH  current PC, wired to `pc_adder.pc_adder_in`.
- pc_adder_out  in  DATA_WIDTH  PC+1 from `pc_adder`.
- fetch_valid  out  1  fetch_addr is a valid request.
- fetch_addr  out  DATA_WIDTH  fetch address; always equals the PC.
- fetch_ready  in  1  memory accepts the request this cycle.
- branch_taken  in  1  one-cycle redirect strobe.
- branch_target  in  DATA_WIDTH  redirect address.
- call  in  1  qualifies branch_taken as a call; pushes the return address.
- ret  in  1  redirect to the popped return address; branch_target is ignored.
- halt_req  in  1  level request to stop fetching.
- resume  in  1  one-cycle strobe to leave HALT.
- halted  out  1  high while in HALT.
- ras_err  out  1  sticky overflow/underflow flag; cleared only by rst.

## Operation
- States: IDLE, FETCH, HALT.
- Reset (async) forces:
  - state=IDLE, pc=RESET_ADDR, fetch_valid=0, halted=0, ras_err=0.
  - RAS pointer=0, count=0.
- IDLE: lasts one cycle. Goes to HALT if halt_req=1, otherwise to FETCH.
- FETCH:
  - fetch_valid=1 and fetch_addr=pc.
  - Accept = fetch_valid & fetch_ready.
- Next-PC priority, highest first:
  1. ret: pc ← RAS top.
  2. branch_taken: pc ← branch_target.
  3. accept: pc ← pc_adder_out.
  4. Otherwise pc holds.
- Redirects are honoured in FETCH and HALT, whether or not an accept occurs. They are ignored in IDLE.
- fetch_addr may change while fetch_valid=1 only as the result of a redirect. Otherwise it is stable until accept.
- Halt:
  - halt_req=1 in FETCH moves to HALT at the end of that cycle. The same-cycle accept and next-PC update still happen.
  - HALT drives fetch_valid=0 and halted=1.
  - A resume pulse moves HALT→FETCH, unless halt_req is still high.
- Wrap-around: pc=2^DATA_WIDTH−1 advances to 0 through the adder. The sequencer applies no range check.
- Simultaneous branch_taken and halt_req: pc takes the target, and the state goes to HALT.

## Timing
- All outputs are registered or decoded from state/pc only. There is no combinational path from any input to any output.
- Redirect latency: branch at cycle N → fetch_addr=target at cycle N+1.
- Sequential throughput: one address per cycle while fetch_ready=1.
- After rst deasserts: first fetch_valid=1 at the 2nd rising edge, with fetch_addr=RESET_ADDR.
- rst asserted mid-handshake: fetch_valid drops immediately (asynchronous); the request is abandoned.

## Configuration
- Macro `PC_SEQ_RAS_EN`.
- Defined:
  - RAS_DEPTH-entry circular return-address stack.
  - call & branch_taken pushes pc_adder_out.
  - ret pops.
  - Push when full overwrites the oldest entry, keeps count=RAS_DEPTH, and sets ras_err.
  - Pop when empty redirects to RESET_ADDR and sets ras_err.
  - call and ret together: ret wins, no push.
- Undefined:
  - No stack storage is built.
  - call and ret are ignored, and ret does not redirect.
  - ras_err is tied to 0.
  - Ports remain present.

## Test plan
- Reset release, fetch_ready=1 constantly → fetch_addr sequence 0,1,2,3 on consecutive cycles starting at cycle 2.
- fetch_ready=0 for 3 cycles at pc=5 → fetch_addr holds 5 with fetch_valid=1, then advances to 6 on the first ready.
- branch_taken, target=0x400, same cycle as accept at pc=9 → next fetch_addr=0x400. pc=0x7FF accepted → next 0x000.
- halt_req at pc=12 with accept → halted=1, fetch_valid=0, pc=13. Resume pulse → fetching restarts at 13.
- With macro: call to 0x100 from pc=0x020, then ret → fetch_addr=0x021. 5 pushes then 5 pops → ras_err=1 and the last pop goes to RESET_ADDR.
- rst asserted while fetch_valid=1 and fetch_ready=0 → fetch_valid=0 immediately, pc=RESET_ADDR.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, issues valid/ready fetch requests,
// applies branch redirects and halt/resume. The PC+1 increment comes from
// the external combinational pc_adder (pc_adder_in -> pc_adder_out).
// Optional return-address stack is compiled in with `define PC_SEQ_RAS_EN.
module pc_sequencer #(
    parameter int                    DATA_WIDTH = 11,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] pc_adder_in,
    input  logic [DATA_WIDTH-1:0] pc_adder_out,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_addr,
    input  logic                  fetch_ready,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  call,
    input  logic                  ret,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  halted,
    output logic                  ras_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  accept;
    logic                  redir_en;
    logic                  do_ret;
    logic [DATA_WIDTH-1:0] ret_addr;

    assign pc_adder_in = pc;
    assign fetch_addr  = pc;
    assign accept      = fetch_valid & fetch_ready;
    // Redirects are dropped during the single IDLE cycle after reset.
    assign redir_en    = (state != IDLE);

`ifdef PC_SEQ_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]         ptr;      // next slot to write; top is ptr-1
    logic [PW:0]           count;
    logic [PW-1:0]         top_idx;
    logic                  do_push;
    logic                  empty;

    assign top_idx  = ptr - 1'b1;
    assign empty    = (count == '0);
    assign do_ret   = redir_en & ret;
    assign do_push  = redir_en & call & branch_taken & ~ret;
    // Popping an empty stack falls back to the reset address.
    assign ret_addr = empty ? RESET_ADDR : stack[top_idx];

    // Stack pointer, occupancy and sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            count   <= '0;
            ras_err <= 1'b0;
        end else if (do_ret) begin
            if (empty) begin
                ras_err <= 1'b1;
            end else begin
                ptr   <= top_idx;
                count <= count - 1'b1;
            end
        end else if (do_push) begin
            ptr <= ptr + 1'b1;
            // Full push wraps over the oldest entry; occupancy saturates.
            if (count == (PW+1)'(RAS_DEPTH)) ras_err <= 1'b1;
            else                             count   <= count + 1'b1;
        end
    end

    // Stack storage; no reset needed, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push) stack[ptr] <= pc_adder_out;
    end
`else
    logic unused_ras;

    assign do_ret     = 1'b0;
    assign ret_addr   = RESET_ADDR;
    assign ras_err    = 1'b0;
    assign unused_ras = ^{call, ret, RAS_DEPTH};
`endif

    // Next-PC select: ret, then branch, then sequential advance on accept.
    always_comb begin
        pc_next = pc;
        if (do_ret)                        pc_next = ret_addr;
        else if (redir_en && branch_taken) pc_next = branch_target;
        else if (accept)                   pc_next = pc_adder_out;
    end

    // Control FSM with registered fetch_valid/halted, plus the PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pc <= pc_next;
            case (state)
                IDLE: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state       <= FETCH;
                        fetch_valid <= 1'b1;
                    end
                end
                FETCH: begin
                    if (halt_req) begin
                        state       <= HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume && !halt_req) begin
                        state       <= FETCH;
                        fetch_valid <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. Models the external
// pc_adder as PC+1. RAS scenarios follow `define PC_SEQ_RAS_EN.
module tb_pc_sequencer;

    localparam int DW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] pc_adder_in, pc_adder_out;
    logic          fetch_valid;
    logic [DW-1:0] fetch_addr;
    logic          fetch_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic [DW-1:0] branch_target = '0;
    logic          call = 1'b0, ret = 1'b0;
    logic          halt_req = 1'b0, resume = 1'b0;
    logic          halted, ras_err;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    assign pc_adder_out = pc_adder_in + 1'b1;

    pc_sequencer #(.DATA_WIDTH(DW), .RESET_ADDR('0), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .pc_adder_in(pc_adder_in), .pc_adder_out(pc_adder_out),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .call(call), .ret(ret),
        .halt_req(halt_req), .resume(resume),
        .halted(halted), .ras_err(ras_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        vecs++;
        if ({fetch_valid, halted, ras_err, fetch_addr} !== {3'b000, 11'h000}) begin
            errs++;
            $display("FAIL reset_state: got v=%b h=%b e=%b a=%h want 0 0 0 000",
                     fetch_valid, halted, ras_err, fetch_addr);
        end
        rst = 1'b0;
        fetch_ready = 1'b1;
        #1;
        vecs++;
        if (fetch_valid !== 1'b0) begin
            errs++;
            $display("FAIL idle_no_valid: got %b want 0", fetch_valid);
        end
    endtask

    // Addresses 0..5 on consecutive cycles, then stall at 5 for three cycles.
    task automatic test_sequential();
        for (int i = 0; i <= 5; i++) begin
            tick();
            vecs++;
            if (fetch_valid !== 1'b1 || fetch_addr !== DW'(i)) begin
                errs++;
                $display("FAIL seq_%0d: got v=%b a=%h want 1 %h", i, fetch_valid, fetch_addr, DW'(i));
            end
        end
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++;
            if (fetch_valid !== 1'b1 || fetch_addr !== 11'h005) begin
                errs++;
                $display("FAIL stall_%0d: got v=%b a=%h want 1 005", i, fetch_valid, fetch_addr);
            end
        end
        fetch_ready = 1'b1;
        tick();
        vecs++;
        if (fetch_addr !== 11'h006) begin
            errs++;
            $display("FAIL stall_release: got %h want 006", fetch_addr);
        end
    endtask

    task automatic test_branch();
        tick(); tick(); tick();   // 7, 8, 9
        vecs++;
        if (fetch_addr !== 11'h009) begin
            errs++;
            $display("FAIL pre_branch: got %h want 009", fetch_addr);
        end
        branch_taken = 1'b1; branch_target = 11'h400;
        tick();
        vecs++;
        if (fetch_addr !== 11'h400) begin
            errs++;
            $display("FAIL branch_accept: got %h want 400", fetch_addr);
        end
        branch_target = 11'h7FF;
        tick();
        branch_taken = 1'b0;
        vecs++;
        if (fetch_addr !== 11'h7FF) begin
            errs++;
            $display("FAIL branch_top: got %h want 7ff", fetch_addr);
        end
        tick();
        vecs++;
        if (fetch_addr !== 11'h000 || fetch_valid !== 1'b1) begin
            errs++;
            $display("FAIL wrap: got v=%b a=%h want 1 000", fetch_valid, fetch_addr);
        end
    endtask

    task automatic test_halt();
        branch_taken = 1'b1; branch_target = 11'h00C;
        tick();
        branch_taken = 1'b0;
        halt_req = 1'b1;
        tick();
        vecs++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0 || fetch_addr !== 11'h00D) begin
            errs++;
            $display("FAIL halt_entry: got h=%b v=%b a=%h want 1 0 00d", halted, fetch_valid, fetch_addr);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        vecs++;
        if (halted !== 1'b1 || fetch_addr !== 11'h00D) begin
            errs++;
            $display("FAIL resume_blocked: got h=%b a=%h want 1 00d", halted, fetch_addr);
        end
        halt_req = 1'b0;
        tick();
        vecs++;
        if (halted !== 1'b1 || fetch_valid !== 1'b0) begin
            errs++;
            $display("FAIL halt_hold: got h=%b v=%b want 1 0", halted, fetch_valid);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        vecs++;
        if (halted !== 1'b0 || fetch_valid !== 1'b1 || fetch_addr !== 11'h00D) begin
            errs++;
            $display("FAIL resume: got h=%b v=%b a=%h want 0 1 00d", halted, fetch_valid, fetch_addr);
        end
        tick();
        vecs++;
        if (fetch_addr !== 11'h00E) begin
            errs++;
            $display("FAIL resume_advance: got %h want 00e", fetch_addr);
        end
        // Branch together with halt: target taken, state halts.
        branch_taken = 1'b1; branch_target = 11'h055; halt_req = 1'b1;
        tick();
        halt_req = 1'b0; branch_target = 11'h060;
        vecs++;
        if (halted !== 1'b1 || fetch_addr !== 11'h055) begin
            errs++;
            $display("FAIL branch_halt: got h=%b a=%h want 1 055", halted, fetch_addr);
        end
        tick();
        branch_taken = 1'b0;
        vecs++;
        if (halted !== 1'b1 || fetch_addr !== 11'h060) begin
            errs++;
            $display("FAIL branch_in_halt: got h=%b a=%h want 1 060", halted, fetch_addr);
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        vecs++;
        if (fetch_valid !== 1'b1 || fetch_addr !== 11'h060) begin
            errs++;
            $display("FAIL resume_at_target: got v=%b a=%h want 1 060", fetch_valid, fetch_addr);
        end
    endtask

    task automatic test_ras();
        logic [DW-1:0] exp_pop [5];
        fetch_ready = 1'b0;
        branch_taken = 1'b1; branch_target = 11'h020;
        tick();
        call = 1'b1; branch_target = 11'h100;
        tick();
        call = 1'b0; branch_taken = 1'b0;
        vecs++;
        if (fetch_addr !== 11'h100) begin
            errs++;
            $display("FAIL call_target: got %h want 100", fetch_addr);
        end
        ret = 1'b1;
        tick();
        ret = 1'b0;
`ifdef PC_SEQ_RAS_EN
        vecs++;
        if (fetch_addr !== 11'h021 || ras_err !== 1'b0) begin
            errs++;
            $display("FAIL ret_addr: got a=%h e=%b want 021 0", fetch_addr, ras_err);
        end
        // Five pushes into a 4-deep stack: return addresses 022,201,202,203,204.
        for (int i = 0; i < 5; i++) begin
            call = 1'b1; branch_taken = 1'b1; branch_target = 11'h200 + DW'(i);
            tick();
            vecs++;
            if (ras_err !== (i == 4)) begin
                errs++;
                $display("FAIL push_err_%0d: got %b want %b", i, ras_err, (i == 4));
            end
        end
        call = 1'b0; branch_taken = 1'b0;
        exp_pop[0] = 11'h204; exp_pop[1] = 11'h203; exp_pop[2] = 11'h202;
        exp_pop[3] = 11'h201; exp_pop[4] = 11'h000;
        for (int i = 0; i < 5; i++) begin
            ret = 1'b1;
            tick();
            vecs++;
            if (fetch_addr !== exp_pop[i]) begin
                errs++;
                $display("FAIL pop_%0d: got %h want %h", i, fetch_addr, exp_pop[i]);
            end
        end
        ret = 1'b0;
        vecs++;
        if (ras_err !== 1'b1) begin
            errs++;
            $display("FAIL ras_err_sticky: got %b want 1", ras_err);
        end
`else
        vecs++;
        if (fetch_addr !== 11'h100 || ras_err !== 1'b0) begin
            errs++;
            $display("FAIL ret_ignored: got a=%h e=%b want 100 0", fetch_addr, ras_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        fetch_ready = 1'b0;
        tick();
        vecs++;
        if (fetch_valid !== 1'b1) begin
            errs++;
            $display("FAIL pre_rst_valid: got %b want 1", fetch_valid);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if (fetch_valid !== 1'b0 || fetch_addr !== 11'h000 || halted !== 1'b0 || ras_err !== 1'b0) begin
            errs++;
            $display("FAIL async_rst: got v=%b a=%h h=%b e=%b want 0 000 0 0",
                     fetch_valid, fetch_addr, halted, ras_err);
        end
        tick();
        rst = 1'b0;
        fetch_ready = 1'b1;
        tick();
        vecs++;
        if (fetch_valid !== 1'b1 || fetch_addr !== 11'h000) begin
            errs++;
            $display("FAIL rst_restart: got v=%b a=%h want 1 000", fetch_valid, fetch_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_halt();
        test_ras();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
